// File: rtl/apb_ram_arbiter.sv
// Round-robin APB master that lets NUM_REQ req/done clients share one APB RAM slave.
// Define APB_ARB_TIMEOUT_EN to end stuck ACCESS phases after TIMEOUT_CYC cycles with an error.
//
// state  | meaning
// IDLE   | bus idle (psel=0), arbitrating among pending requests
// SETUP  | psel=1, penable=0 for exactly one cycle
// ACCESS | psel=1, penable=1 until pready (or timeout) is sampled
module apb_ram_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                        pclk,
  input  logic                        presetn,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          done,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic                        psel,
  output logic                        penable,
  output logic                        pwrite,
  output logic [ADDR_W-1:0]           paddr,
  output logic [DATA_W-1:0]           pwdata,
  input  logic [DATA_W-1:0]           prdata,
  input  logic                        pready,
  input  logic                        pslverr
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SUM_W = IDX_W + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic               psel_q, psel_d;
  logic               penable_q, penable_d;
  logic               pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d;

  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic [SUM_W-1:0]   cand_sum;
  logic               xfer_end;
  logic               end_err;

  // Scan from rr_ptr upward (wrapping); descending loop lets the closest candidate win.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand_sum = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_sum = {1'b0, rr_ptr_q} + SUM_W'(k);
      if (cand_sum >= SUM_W'(NUM_REQ)) cand_sum = cand_sum - SUM_W'(NUM_REQ);
      if (req[cand_sum[IDX_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand_sum[IDX_W-1:0];
      end
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             tmr_expired;

  assign tmr_expired = (tmr_q == '0);

  // Loaded on the grant edge so the first ACCESS cycle sees TIMEOUT_CYC-1.
  always_comb begin
    tmr_d = tmr_q;
    if (state_q == ST_IDLE && pick_vld) begin
      tmr_d = TMR_W'(TIMEOUT_CYC - 1);
    end else if (state_q == ST_ACCESS && !tmr_expired) begin
      tmr_d = tmr_q - TMR_W'(1);
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) tmr_q <= '0;
    else          tmr_q <= tmr_d;
  end

  assign xfer_end = pready || tmr_expired;
  assign end_err  = pslverr || (!pready && tmr_expired);
`else
  assign xfer_end = pready;
  assign end_err  = pslverr;
`endif

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    case (state_q)
      ST_IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (pick_vld) begin
          state_d  = ST_SETUP;
          owner_d  = pick_idx;
          gnt_d    = NUM_REQ'(1) << pick_idx;
          psel_d   = 1'b1;
          pwrite_d = req_write[pick_idx];
          paddr_d  = req_addr[pick_idx*ADDR_W +: ADDR_W];
          pwdata_d = req_wdata[pick_idx*DATA_W +: DATA_W];
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (xfer_end) begin
          psel_d           = 1'b0;
          penable_d        = 1'b0;
          gnt_d            = '0;
          done_d[owner_q]  = 1'b1;
          rsp_err_d        = end_err;
          rsp_rdata_d      = pwrite_q ? '0 : prdata;
          rr_ptr_d         = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
          state_d          = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_ram_arbiter.sv
// Bench for apb_ram_arbiter: APB RAM slave model, per-requester expected-response queues
// fed at issue time, and a negedge monitor that pops and compares on every done pulse.
module tb_apb_ram_arbiter;

  localparam int NUM_REQ     = 2;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int TIMEOUT_CYC = 16;

  logic                      pclk = 1'b0;
  logic                      presetn = 1'b0;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ-1:0]        req_write = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ*DATA_W-1:0] req_wdata = '0;
  logic [NUM_REQ-1:0]        gnt, done;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err, psel, penable, pwrite;
  logic [ADDR_W-1:0]         paddr;
  logic [DATA_W-1:0]         pwdata;
  logic [DATA_W-1:0]         prdata;
  logic                      pready, pslverr;

  apb_ram_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .pclk(pclk), .presetn(presetn), .req(req), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q [NUM_REQ][$];
  int          gnt_log[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] ref_mem [32];
  logic [31:0] ram [32];
  bit          ram_init = 1'b0;
  bit          stall_force = 1'b0;
  bit          rand_stall = 1'b0;
  bit          rdy_rand = 1'b1;

  function automatic logic [31:0] init_word(input int k);
    return 32'hA500_0000 | 32'(k);
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // APB RAM slave: 32 words, error beyond the array, optional wait states
  always_comb begin
    pready  = !stall_force && rdy_rand;
    pslverr = (paddr >= 32);
    prdata  = (paddr < 32) ? ram[paddr[4:0]] : '0;
  end

  always @(negedge pclk) rdy_rand = rand_stall ? ($urandom_range(0, 2) != 0) : 1'b1;

  always @(posedge pclk) begin
    if (!ram_init) begin
      for (int k = 0; k < 32; k++) ram[k] = init_word(k);
      ram_init = 1'b1;
    end else if (psel && penable && pready && pwrite && paddr < 32) begin
      ram[paddr[4:0]] = pwdata;
    end
  end

  // Monitor / scoreboard
  logic [NUM_REQ-1:0] gnt_prev = '0;
  bit                 done_prev = 1'b0;

  always @(negedge pclk) begin
    exp_t e;
    if (presetn) begin
      if (done_prev && done == '0) begin
        chk("rsp_rdata_clear", rsp_rdata, 0);
        chk("rsp_err_clear", rsp_err, 0);
      end
      chk("done_onehot", $onehot0(done), 1);
      chk("gnt_onehot", $onehot0(gnt), 1);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (done[i]) begin
          chk("done_psel_low", psel, 0);
          chk("done_gnt_clear", gnt, 0);
          if (exp_q[i].size() == 0) begin
            chk($sformatf("unexpected_done_req%0d", i), 1, 0);
          end else begin
            e = exp_q[i].pop_front();
            chk($sformatf("rdata_req%0d", i), rsp_rdata, e.rdata);
            chk($sformatf("err_req%0d", i), rsp_err, e.err);
          end
        end
      end
      if (gnt != '0 && gnt_prev == '0)
        for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) gnt_log.push_back(i);
    end
    gnt_prev  = presetn ? gnt : '0;
    done_prev = presetn && (done != '0);
  end

  task automatic issue(input int i, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, input bit force_err = 1'b0);
    exp_t e;
    e.err   = (addr >= 32) || force_err;
    e.rdata = (!wr && addr < 32) ? ref_mem[addr[4:0]] : 32'h0;
    if (wr && addr < 32) ref_mem[addr[4:0]] = wd;
    exp_q[i].push_back(e);
    req_write[i] = wr;
    req_addr[i*ADDR_W +: ADDR_W]  = addr;
    req_wdata[i*DATA_W +: DATA_W] = wd;
    req[i] = 1'b1;
  endtask

  task automatic wait_done(input int i, output int others);
    others = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge pclk);
      if (done[i]) return;
      for (int j = 0; j < NUM_REQ; j++) if (j != i && done[j]) others++;
    end
    chk($sformatf("done_timeout_req%0d", i), 0, 1);
  endtask

  task automatic wait_access();
    for (int c = 0; c < 50; c++) begin
      @(negedge pclk);
      if (penable) return;
    end
    chk("access_timeout", 0, 1);
  endtask

  task automatic drive(input int i);
    int          oth;
    bit          wr;
    logic [31:0] a;
    for (int n = 0; n < 30; n++) begin
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 7) == 0) ? 32'(32 + $urandom_range(0, 200))
                                       : 32'(i * 16 + $urandom_range(0, 15));
      issue(i, wr, a, $urandom);
      wait_done(i, oth);
      chk($sformatf("rr_wait_req%0d", i), oth <= NUM_REQ - 1, 1);
      if ($urandom_range(0, 1) == 0 || n == 29) begin
        req[i] = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge pclk);
      end
    end
  endtask

  initial begin
    int oth, n, acc, base;
    bit got;
    for (int k = 0; k < 32; k++) ref_mem[k] = init_word(k);

    // Reset values
    presetn = 1'b0;
    repeat (3) @(negedge pclk);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    presetn = 1'b1;
    @(negedge pclk);

    // Both requesters held: grants alternate starting at req0
    gnt_log.delete();
    issue(0, 1'b0, 2, 0);
    issue(1, 1'b0, 18, 0);
    n = 0;
    for (int c = 0; c < 200 && n < 4; c++) begin
      @(negedge pclk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (done[i]) begin
          n++;
          if (n <= 2) issue(i, 1'b0, (i == 1) ? 32'd18 : 32'd2, 0);
          else        req[i] = 1'b0;
        end
      end
    end
    chk("alt_done_count", n, 4);
    for (int j = 0; j < 4; j++)
      chk($sformatf("alt_order_%0d", j), (gnt_log.size() > j) ? gnt_log[j] : 99, j % 2);

    // Out-of-range address errors, next in-range transfer is clean
    issue(1, 1'b0, 40, 0);
    wait_done(1, oth);
    chk("addr40_err", rsp_err, 1);
    issue(1, 1'b0, 3, 0);
    wait_done(1, oth);
    chk("addr3_err", rsp_err, 0);
    req[1] = 1'b0;
    @(negedge pclk);

    // Slave stalls pready for 20 cycles
    stall_force = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
    issue(1, 1'b0, 20, 0, 1'b1);
`else
    issue(1, 1'b0, 20, 0);
`endif
    acc = 0;
    got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge pclk);
      if (done[1]) begin got = 1'b1; break; end
      if (penable) acc++;
      if (acc == 20) stall_force = 1'b0;
    end
    chk("stall_done_seen", got, 1);
`ifdef APB_ARB_TIMEOUT_EN
    chk("stall_access_cycles", acc, TIMEOUT_CYC);
    chk("stall_timeout_err", rsp_err, 1);
`else
    chk("stall_access_cycles", acc, 20);
    chk("stall_err", rsp_err, 0);
`endif
    stall_force = 1'b0;
    req[1] = 1'b0;
    @(negedge pclk);

    // Write then read back from req0
    issue(0, 1'b1, 5, 32'hDEADBEEF);
    wait_done(0, oth);
    issue(0, 1'b0, 5, 0);
    wait_done(0, oth);
    req[0] = 1'b0;
    chk("readback_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("readback_err", rsp_err, 0);
    @(negedge pclk);

    // Reset in the middle of ACCESS abandons the transfer and rewinds the pointer
    stall_force = 1'b1;
    issue(1, 1'b0, 7, 0);
    wait_access();
    presetn = 1'b0;
    req[1] = 1'b0;
    @(negedge pclk);
    chk("midrst_psel", psel, 0);
    chk("midrst_penable", penable, 0);
    chk("midrst_gnt", gnt, 0);
    chk("midrst_done", done, 0);
    exp_q[1].delete();
    presetn = 1'b1;
    stall_force = 1'b0;
    gnt_log.delete();
    issue(0, 1'b0, 4, 0);
    issue(1, 1'b0, 17, 0);
    wait_done(0, oth);
    req[0] = 1'b0;
    chk("midrst_first_gnt", (gnt_log.size() > 0) ? gnt_log[0] : 99, 0);
    wait_done(1, oth);
    req[1] = 1'b0;
    @(negedge pclk);

    // Requester drops req during SETUP: completes once, no regrant
    base = gnt_log.size();
    issue(0, 1'b1, 9, $urandom);
    for (int c = 0; c < 50; c++) begin
      @(negedge pclk);
      if (psel && !penable) break;
    end
    req[0] = 1'b0;
    wait_done(0, oth);
    repeat (8) @(negedge pclk);
    chk("setup_drop_grants", gnt_log.size() - base, 1);

    // Randomised traffic with wait states
    rand_stall = 1'b1;
    fork
      drive(0);
      drive(1);
    join
    rand_stall = 1'b0;
    repeat (10) @(negedge pclk);
    for (int i = 0; i < NUM_REQ; i++)
      chk($sformatf("leftover_exp_req%0d", i), exp_q[i].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
